// File: rtl/reset_sequencer.sv
// reset_sequencer: drives the per-block reset lines for downstream counter/register blocks.
// Keeps every stage in reset for HOLD_CYC cycles after master reset or a debounced soft
// request, then releases stage 0 .. N_STAGES-1 in order, GAP_CYC cycles apart.
// All outputs come straight from flops.
module reset_sequencer #(
    parameter int N_STAGES = 4,
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              REQ_IN,
    output logic [N_STAGES-1:0]               RST_OUT,
    output logic                              BUSY,
    output logic                              DONE,
    output logic [$clog2(N_STAGES+1)-1:0]     STAGE_IDX
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int RW = $clog2(DEBOUNCE + 1);
    localparam int IW = $clog2(N_STAGES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
    localparam logic [RW-1:0] REQ_MAX   = RW'(DEBOUNCE);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);
    localparam logic [IW-1:0] IDX_ALL   = IW'(N_STAGES);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [N_STAGES-1:0] STAGE0 = N_STAGES'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_RELEASE
    } state_t;

    state_t                state_q;
    logic [N_STAGES-1:0]   rst_out_q;
    logic [HW-1:0]         hold_q;
    logic [GW-1:0]         gap_q;
    logic [IW-1:0]         idx_q;
    logic                  done_q;
    logic                  busy_q;

    logic [RW-1:0]         req_cnt_q;
    logic [RW-1:0]         req_cnt_d;
    logic                  req_db_q;

    // Saturating count of consecutive high REQ_IN samples; any low sample clears it.
    always_comb begin
        req_cnt_d = '0;
        if (REQ_IN) begin
            if (req_cnt_q == REQ_MAX) begin
                req_cnt_d = req_cnt_q;
            end else begin
                req_cnt_d = req_cnt_q + 1'b1;
            end
        end
    end

    // Debounce registers: req_db_q tracks req_cnt_q == DEBOUNCE, so the FSM sees it one edge later.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_cnt_q <= '0;
            req_db_q  <= 1'b0;
        end else begin
            req_cnt_q <= req_cnt_d;
            req_db_q  <= (req_cnt_d == REQ_MAX);
        end
    end

    // Sequencing FSM: hold all stages, then release one stage per gap; a qualified request restarts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_ASSERT;
            rst_out_q <= '1;
            hold_q    <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_ASSERT: begin
                    rst_out_q <= '1;
                    if (req_db_q) begin
                        hold_q <= '0;
                        busy_q <= 1'b1;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_q <= '0;
                        gap_q  <= '0;
                        idx_q  <= IDX_ONE;
                        if (N_STAGES == 1) begin
                            state_q   <= S_IDLE;
                            rst_out_q <= '0;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            state_q   <= S_RELEASE;
                            rst_out_q <= ~STAGE0;
                            busy_q    <= 1'b1;
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                        busy_q <= 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (req_db_q) begin
                        state_q   <= S_ASSERT;
                        rst_out_q <= '1;
                        hold_q    <= '0;
                        gap_q     <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                    end else if (gap_q == GAP_LAST) begin
                        rst_out_q <= rst_out_q & ~(STAGE0 << idx_q);
                        idx_q     <= idx_q + 1'b1;
                        gap_q     <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        gap_q  <= gap_q + 1'b1;
                        busy_q <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (req_db_q) begin
                        state_q   <= S_ASSERT;
                        rst_out_q <= '1;
                        hold_q    <= '0;
                        gap_q     <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                    end else begin
                        rst_out_q <= '0;
                        idx_q     <= IDX_ALL;
                        busy_q    <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= S_ASSERT;
                    rst_out_q <= '1;
                    hold_q    <= '0;
                    gap_q     <= '0;
                    idx_q     <= '0;
                    busy_q    <= 1'b1;
                end
            endcase
        end
    end

    assign RST_OUT   = rst_out_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign STAGE_IDX = idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table-driven checks of reset_sequencer with default parameters,
// plus a hand-written sequence for the 1/1/1/1 configuration.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst0 = 1'b1;
    logic       req0 = 1'b0;
    logic [3:0] rst_out0;
    logic       busy0;
    logic       done0;
    logic [2:0] idx0;

    logic       rst1 = 1'b1;
    logic       req1 = 1'b0;
    logic [0:0] rst_out1;
    logic       busy1;
    logic       done1;
    logic [0:0] idx1;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned done_pulses = 0;

    typedef struct packed {
        logic [3:0] out;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        req;
        int unsigned n;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    vec_t vecs1[$];

    always #5 clk = ~clk;

    reset_sequencer #(
        .N_STAGES (4),
        .HOLD_CYC (16),
        .GAP_CYC  (4),
        .DEBOUNCE (3)
    ) dut0 (
        .CLK       (clk),
        .RST       (rst0),
        .REQ_IN    (req0),
        .RST_OUT   (rst_out0),
        .BUSY      (busy0),
        .DONE      (done0),
        .STAGE_IDX (idx0)
    );

    reset_sequencer #(
        .N_STAGES (1),
        .HOLD_CYC (1),
        .GAP_CYC  (1),
        .DEBOUNCE (1)
    ) dut1 (
        .CLK       (clk),
        .RST       (rst1),
        .REQ_IN    (req1),
        .RST_OUT   (rst_out1),
        .BUSY      (busy1),
        .DONE      (done1),
        .STAGE_IDX (idx1)
    );

    // Count DONE pulses of the default instance over the whole run.
    always @(negedge clk) begin
        if (done0) done_pulses++;
    end

    function automatic vec_t mk(input logic r, input logic q, input int unsigned n,
                                input logic [3:0] o, input logic b, input logic d,
                                input logic [2:0] i);
        vec_t v;
        v.rst    = r;
        v.req    = q;
        v.n      = n;
        v.e.out  = o;
        v.e.busy = b;
        v.e.done = d;
        v.e.idx  = i;
        return v;
    endfunction

    task automatic chk(input int unsigned id, input string nm,
                       input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL v%0d %s got %h want %h", id, nm, got, want);
        end
    endtask

    // Drive one vector, push its expectation, wait n edges, then pop and compare.
    task automatic run_vec(input int unsigned id, input bit sel, input vec_t v);
        exp_t want;
        exp_t got;
        if (sel) begin
            rst1 = v.rst;
            req1 = v.req;
        end else begin
            rst0 = v.rst;
            req0 = v.req;
        end
        sb.push_back(v.e);
        repeat (v.n) @(posedge clk);
        #1;
        if (sel) got = '{out: {3'b000, rst_out1}, busy: busy1, done: done1, idx: {2'b00, idx1}};
        else     got = '{out: rst_out0, busy: busy0, done: done0, idx: idx0};
        want = sb.pop_front();
        chk(id, "rst_out",   got.out,               want.out);
        chk(id, "busy",      {3'b000, got.busy},    {3'b000, want.busy});
        chk(id, "done",      {3'b000, got.done},    {3'b000, want.done});
        chk(id, "stage_idx", {1'b0, got.idx},       {1'b0, want.idx});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-up hold and ordered release
        vecs.push_back(mk(1, 0,  3, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 14, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 4'hE, 1, 0, 1));
        vecs.push_back(mk(0, 0,  3, 4'hE, 1, 0, 1));
        vecs.push_back(mk(0, 0,  1, 4'hC, 1, 0, 2));
        vecs.push_back(mk(0, 0,  4, 4'h8, 1, 0, 3));
        vecs.push_back(mk(0, 0,  3, 4'h8, 1, 0, 3));
        vecs.push_back(mk(0, 0,  1, 4'h0, 0, 1, 4));
        vecs.push_back(mk(0, 0,  1, 4'h0, 0, 0, 4));
        vecs.push_back(mk(0, 0,  4, 4'h0, 0, 0, 4));
        // Debounce: short request ignored, full-length one accepted
        vecs.push_back(mk(0, 1,  2, 4'h0, 0, 0, 4));
        vecs.push_back(mk(0, 0,  3, 4'h0, 0, 0, 4));
        vecs.push_back(mk(0, 1,  3, 4'h0, 0, 0, 4));
        vecs.push_back(mk(0, 0,  1, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 15, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 4'hE, 1, 0, 1));
        vecs.push_back(mk(0, 0,  4, 4'hC, 1, 0, 2));
        // Request during release restarts the full sequence
        vecs.push_back(mk(0, 1,  3, 4'hC, 1, 0, 2));
        vecs.push_back(mk(0, 0,  1, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 15, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 4'hE, 1, 0, 1));
        vecs.push_back(mk(0, 0,  4, 4'hC, 1, 0, 2));
        vecs.push_back(mk(0, 0,  4, 4'h8, 1, 0, 3));
        vecs.push_back(mk(0, 0,  4, 4'h0, 0, 1, 4));
        vecs.push_back(mk(0, 0,  1, 4'h0, 0, 0, 4));
        // Long request stretches the hold
        vecs.push_back(mk(0, 1,  4, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 1, 36, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 15, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 4'hE, 1, 0, 1));
        // Master reset in the middle of release
        vecs.push_back(mk(0, 0,  4, 4'hC, 1, 0, 2));
        vecs.push_back(mk(0, 0,  4, 4'h8, 1, 0, 3));
        vecs.push_back(mk(1, 0,  1, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 15, 4'hF, 1, 0, 0));
        vecs.push_back(mk(0, 0,  1, 4'hE, 1, 0, 1));
        vecs.push_back(mk(0, 0,  4, 4'hC, 1, 0, 2));
        vecs.push_back(mk(0, 0,  4, 4'h8, 1, 0, 3));
        vecs.push_back(mk(0, 0,  3, 4'h8, 1, 0, 3));
        vecs.push_back(mk(0, 0,  1, 4'h0, 0, 1, 4));
        vecs.push_back(mk(0, 0,  1, 4'h0, 0, 0, 4));

        // Minimal configuration: one stage, one-cycle hold, one-sample debounce
        vecs1.push_back(mk(1, 0, 2, 4'h1, 1, 0, 0));
        vecs1.push_back(mk(0, 0, 1, 4'h0, 0, 1, 1));
        vecs1.push_back(mk(0, 0, 1, 4'h0, 0, 0, 1));
        vecs1.push_back(mk(0, 1, 1, 4'h0, 0, 0, 1));
        vecs1.push_back(mk(0, 0, 1, 4'h1, 1, 0, 0));
        vecs1.push_back(mk(0, 0, 1, 4'h0, 0, 1, 1));
        vecs1.push_back(mk(0, 0, 1, 4'h0, 0, 0, 1));

        foreach (vecs[k]) run_vec(k, 1'b0, vecs[k]);
        foreach (vecs1[k]) run_vec(100 + k, 1'b1, vecs1[k]);

        chk(999, "done_pulses", 4'(done_pulses), 4'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
